// File: rtl/pynq_io_pkg.sv
// Shared constants for the button/switch conditioner.
// Channel numbering: buttons 0-3 occupy channels 0-3, slide switches
// sw0/sw1 occupy channels 4/5. Events are {rise, chan[2:0]}.
package pynq_io_pkg;

    localparam int NUM_CH = 6;
    localparam int EVT_W  = 4;
    localparam int CNT_W  = 24;

    localparam int CH_BTN0 = 0;
    localparam int CH_BTN1 = 1;
    localparam int CH_BTN2 = 2;
    localparam int CH_BTN3 = 3;
    localparam int CH_SW0  = 4;
    localparam int CH_SW1  = 5;

    typedef logic [2:0] chan_t;

    function automatic logic [EVT_W-1:0] pack_evt(input logic rise, input chan_t ch);
        return {rise, ch};
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced input channel: 2-flop synchronizer, stability counter
// and debounced level register.
// Ports:
//   CLK, RST_N  - clock, async active-low reset
//   raw         - raw asynchronous level
//   level       - debounced level
//   tgl         - high in the cycle whose closing edge flips level
//   tgl_rise    - polarity of that flip (1 = 0->1)
module debounce_chan
    import pynq_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level,
    output logic tgl,
    output logic tgl_rise
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             differ;
    logic             at_tc;

    assign differ   = sync_q[1] ^ level_q;
    assign at_tc    = (cnt_q == TC);
    // Sample still differs after DEBOUNCE_CYCLES counts: flip on this edge.
    assign tgl      = differ & at_tc;
    assign tgl_rise = sync_q[1];
    assign level    = level_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (!differ || at_tc) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (tgl) begin
                level_q <= ~level_q;
            end
        end
    end

endmodule

// File: rtl/btn_sw_conditioner.sv
// Debounces 4 buttons and 2 slide switches, and queues an edge event per
// debounced level change into a small FIFO for a valid/ready consumer.
// Ports:
//   CLK, RST_N          - clock, async active-low reset
//   btn[3:0], sw0, sw1  - raw asynchronous inputs (channels 0-3, 4, 5)
//   btn_level, sw_level - debounced levels
//   evt_valid/evt_data/evt_ready - event stream, evt_data = {rise, chan}
//   ovf, ovf_clr        - sticky lost-event flag and its synchronous clear
module btn_sw_conditioner
    import pynq_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       btn,
    input  logic             sw0,
    input  logic             sw1,
    output logic [3:0]       btn_level,
    output logic [1:0]       sw_level,
    output logic             evt_valid,
    output logic [EVT_W-1:0] evt_data,
    input  logic             evt_ready,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] level_vec;
    logic [NUM_CH-1:0] tgl_vec;
    logic [NUM_CH-1:0] rise_vec;

    assign raw_vec = {sw1, sw0, btn};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .raw      (raw_vec[g]),
            .level    (level_vec[g]),
            .tgl      (tgl_vec[g]),
            .tgl_rise (rise_vec[g])
        );
    end

    assign btn_level = level_vec[CH_BTN3:CH_BTN0];
    assign sw_level  = level_vec[CH_SW1:CH_SW0];

    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pol_q;
    logic              ovf_q;

    logic [EVT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              full;
    logic              empty;
    logic              pop;

    logic              any_pend;
    chan_t             sel_ch;
    logic [NUM_CH-1:0] push_mask;
    logic              push_en;
    logic              ovf_set;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && evt_ready;

    // Fixed-priority arbiter; scanning downward lets the lowest index win.
    always_comb begin
        any_pend = 1'b0;
        sel_ch   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                any_pend = 1'b1;
                sel_ch   = chan_t'(i);
            end
        end
    end

    assign push_en = any_pend && !full;

    always_comb begin
        push_mask = '0;
        if (push_en) begin
            push_mask[sel_ch] = 1'b1;
        end
    end

    // A toggle onto a still-pending flag loses the older event, unless that
    // older event is leaving for the FIFO on this very edge.
    assign ovf_set = |(tgl_vec & pend_q & ~push_mask);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
            pol_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (tgl_vec[i]) begin
                    pend_q[i] <= 1'b1;
                    pol_q[i]  <= rise_vec[i];
                end else if (push_mask[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= pack_evt(pol_q[sel_ch], sel_ch);
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    assign evt_valid = !empty;
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

endmodule

// File: tb/tb_btn_sw_conditioner.sv
module tb_btn_sw_conditioner;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] btn;
    logic       sw0, sw1;
    logic [3:0] btn_level;
    logic [1:0] sw_level;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic       evt_ready;
    logic       ovf;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;

    btn_sw_conditioner #(
        .DEBOUNCE_CYCLES (16),
        .FIFO_DEPTH      (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .btn       (btn),
        .sw0       (sw0),
        .sw1       (sw1),
        .btn_level (btn_level),
        .sw_level  (sw_level),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N = 1'b0; btn = 4'b0; sw0 = 1'b0; sw1 = 1'b0;
        evt_ready = 1'b1; ovf_clr = 1'b0;
        tick(3);
        chk("rst_btn_level", 8'(btn_level), 8'h0);
        chk("rst_sw_level",  8'(sw_level),  8'h0);
        chk("rst_valid",     8'(evt_valid), 8'h0);
        chk("rst_data",      8'(evt_data),  8'h0);
        chk("rst_ovf",       8'(ovf),       8'h0);
        RST_N = 1'b1;
        tick(2);

        // btn0 rise, consumer ready
        btn[0] = 1'b1;
        tick(17);
        chk("b0_lvl_c17", 8'(btn_level), 8'h0);
        tick(1);
        chk("b0_lvl_c18", 8'(btn_level), 8'h1);
        chk("b0_nv_c18",  8'(evt_valid), 8'h0);
        tick(1);
        chk("b0_valid",   8'(evt_valid), 8'h1);
        chk("b0_data",    8'(evt_data),  8'h8);
        tick(1);
        chk("b0_popped",  8'(evt_valid), 8'h0);

        // 10-cycle glitch on btn2
        btn[2] = 1'b1;
        tick(10);
        btn[2] = 1'b0;
        tick(30);
        chk("glitch_lvl",   8'(btn_level), 8'h1);
        chk("glitch_noevt", 8'(evt_valid), 8'h0);

        // btn1, btn3, sw1 rise together; consumer stalled
        evt_ready = 1'b0;
        btn[1] = 1'b1; btn[3] = 1'b1; sw1 = 1'b1;
        tick(18);
        chk("multi_btn_lvl", 8'(btn_level), 8'hB);
        chk("multi_sw_lvl",  8'(sw_level),  8'h2);
        tick(4);
        chk("multi_v",  8'(evt_valid), 8'h1);
        chk("multi_e0", 8'(evt_data),  8'h9);
        tick(2);
        chk("multi_hold", 8'(evt_data), 8'h9);
        evt_ready = 1'b1;
        tick(1);
        chk("multi_e1", 8'(evt_data), 8'hB);
        tick(1);
        chk("multi_e2", 8'(evt_data), 8'hD);
        tick(1);
        chk("multi_empty", 8'(evt_valid), 8'h0);
        evt_ready = 1'b0;

        // all six channels toggle with consumer stalled
        btn = 4'b0100; sw0 = 1'b1; sw1 = 1'b0;
        tick(18);
        chk("six_btn_lvl", 8'(btn_level), 8'h4);
        chk("six_sw_lvl",  8'(sw_level),  8'h1);
        tick(6);
        chk("six_head", 8'(evt_data), 8'h0);
        chk("six_ovf0", 8'(ovf),      8'h0);

        // ch0 toggles twice while FIFO full: second one overwrites
        btn[0] = 1'b1;
        tick(18);
        chk("ch0_first_noovf", 8'(ovf), 8'h0);
        btn[0] = 1'b0;
        tick(17);
        chk("ch0_pre_ovf", 8'(ovf), 8'h0);
        tick(1);
        chk("ch0_ovf", 8'(ovf), 8'h1);
        ovf_clr = 1'b1;
        tick(1);
        chk("ovf_cleared", 8'(ovf), 8'h0);
        ovf_clr = 1'b0;

        // drain: four queued, then ch0 (fall, overwritten), ch4 rise, ch5 fall
        evt_ready = 1'b1;
        chk("drain0", 8'(evt_data), 8'h0);
        tick(1); chk("drain1", 8'(evt_data), 8'h1);
        tick(1); chk("drain2", 8'(evt_data), 8'hA);
        tick(1); chk("drain3", 8'(evt_data), 8'h3);
        tick(1); chk("drain4", 8'(evt_data), 8'h0);
        chk("drain4_v", 8'(evt_valid), 8'h1);
        tick(1); chk("drain5", 8'(evt_data), 8'hC);
        tick(1); chk("drain6", 8'(evt_data), 8'h5);
        tick(1); chk("drain_empty", 8'(evt_valid), 8'h0);

        // reset mid-count with sw0 held high
        btn[2] = 1'b0;
        tick(8);
        RST_N = 1'b0;
        #1;
        chk("mrst_btn", 8'(btn_level), 8'h0);
        chk("mrst_sw",  8'(sw_level),  8'h0);
        chk("mrst_v",   8'(evt_valid), 8'h0);
        chk("mrst_ovf", 8'(ovf),       8'h0);
        tick(3);
        RST_N = 1'b1;
        tick(17);
        chk("rel_sw_c17", 8'(sw_level), 8'h0);
        tick(1);
        chk("rel_sw_c18", 8'(sw_level),  8'h1);
        chk("rel_btn",    8'(btn_level), 8'h0);
        tick(1);
        chk("rel_v",    8'(evt_valid), 8'h1);
        chk("rel_data", 8'(evt_data),  8'hC);
        tick(1);
        chk("rel_empty", 8'(evt_valid), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_sw_conditioner.md
BTN_SW_CONDITIONER -- requirements
Module: btn_sw_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the required stable duration in CLK cycles (10 ms at FCLK0 = 100 MHz); legal range 8..2^24-1.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set event FIFO entries (power of two, 2..16).
REQ-003 CLK  input  1  SHALL be the single clock (FCLKCLK[0] domain).
REQ-004 RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 btn  input  4  SHALL carry raw asynchronous push-button levels, channels 0-3.
REQ-006 sw0, sw1  input  1 each  SHALL carry raw asynchronous slide-switch levels, channels 4 and 5.
REQ-007 btn_level  output  4  SHALL carry debounced button levels.
REQ-008 sw_level  output  2  SHALL carry debounced switch levels: bit0 = sw0, bit1 = sw1.
REQ-009 evt_valid  output  1  SHALL flag that evt_data holds an unconsumed event.
REQ-010 evt_data  output  4  SHALL be {rise, chan[2:0]}: rise=1 for 0->1, rise=0 for 1->0.
REQ-011 evt_ready  input  1  SHALL be the consumer acceptance signal.
REQ-012 ovf  output  1  SHALL be the sticky event-lost flag.
REQ-013 ovf_clr  input  1  SHALL clear ovf synchronously.

Function
REQ-014 Each raw input SHALL pass a 2-flop synchronizer before any other logic.
REQ-015 Per channel: counter clears when synchronized sample equals debounced level; otherwise increments.
REQ-016 Debounced level SHALL toggle, and counter clear, on the cycle after the counter reaches DEBOUNCE_CYCLES-1 with the sample still differing.
REQ-017 Raw change held stable SHALL appear on the level output exactly DEBOUNCE_CYCLES+2 cycles later; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-018 Each level toggle SHALL set that channel's pending flag with its polarity.
REQ-019 Arbiter SHALL push at most one pending event per cycle into the FIFO, lowest channel index first, and only when FIFO is not full; the pushed channel's pending flag clears.
REQ-020 Toggle on a channel whose pending flag is already set SHALL overwrite its polarity and set ovf.
REQ-021 Toggle and arbiter push of the same channel in the same cycle SHALL push the old event and leave the new one pending, without setting ovf.
REQ-022 Transfer occurs when evt_valid and evt_ready are both high; evt_data SHALL stay stable while evt_valid is high and evt_ready low.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; pop on empty is ignored.
REQ-024 evt_valid SHALL assert the cycle after the first push into an empty FIFO (1-cycle FIFO latency), events delivered in push order.
REQ-025 ovf_clr coincident with a new overflow SHALL leave ovf set.

Reset
REQ-026 RST_N low SHALL asynchronously clear synchronizers, counters, levels, pending flags, FIFO pointers, ovf; evt_valid=0, btn_level=0, sw_level=0, evt_data=0.
REQ-027 Reset mid-debounce SHALL discard partial counts and queued events; input high through reset yields a rise event DEBOUNCE_CYCLES+2 cycles after release.

Structure
REQ-028 Package pynq_io_pkg SHALL hold channel constants (CH_BTN0..CH_BTN3=0..3, CH_SW0=4, CH_SW1=5), NUM_CH=6, EVT_W=4.
REQ-029 Sub-module debounce_chan (synchronizer + counter + level) SHALL be instantiated NUM_CH times; arbiter and FIFO stay in the top.

Verification (DEBOUNCE_CYCLES=16, FIFO_DEPTH=4)
REQ-030 btn[0] 0->1 held, evt_ready=1 -> btn_level[0]=1 at cycle 18, evt_data=4'h8 valid one cycle later.
REQ-031 btn[2] pulse 10 cycles wide -> btn_level unchanged, no event.
REQ-032 btn[1], btn[3], sw1 rise same cycle -> events 4'h9, 4'hB, 4'hD in that order.
REQ-033 evt_ready=0, six channels toggle -> four events queued, two pending; second toggle of channel 0 before drain -> ovf=1; ovf_clr -> ovf=0.
REQ-034 RST_N low mid-count with sw0 high -> all outputs 0; after release, sw_level[0]=1 at cycle 18, event 4'hC.
